// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the memory access unit: FSM states, access sizes,
// the captured request record and the lane/enable helpers used on the bus side.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  localparam int TIMEOUT_CYC_DEF = 16;

  typedef struct packed {
    logic        rw;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic align_ok(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lo[0];
      SZ_WORD: return (lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data is replicated across all lanes; the byte enables pick the lane.
  function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load alignment: selects the addressed byte/halfword lane of the raw read word
// and zero- or sign-extends it to 32 bits. Words pass through untouched.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lo_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata_i[{lo_i, 3'b000} +: 8];
    lane_h = lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = {{24{sign_ext_i & lane_b[7]}}, lane_b};
      SZ_HALF: data_o = {{16{sign_ext_i & lane_h[15]}}, lane_h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns a one-cycle load/store strobe into a single bus
// transaction with alignment checking, ack timeout and aligned load return.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        rw_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] dy_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

  state_e      state_q, state_d;
  mem_req_t    req_q, req_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] dy_q, dy_d;
  logic        mis_q, mis_d;
  logic        tmo_q, tmo_d;
  logic [31:0] ld_data;

  load_align u_load_align (
    .rdata_i   (mem_rdata_i),
    .lo_i      (req_q.addr[1:0]),
    .size_i    (req_q.size),
    .sign_ext_i(req_q.sign_ext),
    .data_o    (ld_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      dy_q    <= '0;
      mis_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      dy_q    <= dy_d;
      mis_q   <= mis_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    dy_d    = dy_q;
    mis_d   = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          // Misaligned requests never reach the bus; they report straight from DONE.
          if (align_ok(size_i, addr_i[1:0])) begin
            req_d   = '{rw: rw_i, size: size_i, sign_ext: sign_ext_i,
                        addr: addr_i, wdata: wdata_i};
            cnt_d   = '0;
            state_d = ST_REQ;
          end else begin
            mis_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack_i) begin
          if (!req_q.rw) dy_d = ld_data;
          state_d = ST_DONE;
        end else if (cnt_q + 8'd1 == TMO) begin
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req_o   = (state_q == ST_REQ);
  assign mem_we_o    = mem_req_o & req_q.rw;
  assign mem_be_o    = mem_req_o ? byte_en(req_q.size, req_q.addr[1:0]) : 4'b0000;
  assign mem_addr_o  = {req_q.addr[31:2], 2'b00};
  assign mem_wdata_o = lane_rep(req_q.size, req_q.wdata);
  assign dy_o        = dy_q;
  assign done_o      = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);
  assign misalign_o  = mis_q;
  assign timeout_o   = tmo_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver issues requests and queues the
// expected bus/completion results from a reference model; monitors pop and compare.
module tb_mem_access_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        sext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] mem_addr_o, mem_wdata_o, dy_o;
  logic [3:0]  mem_be_o;
  logic        mem_req_o, mem_we_o, done_o, busy_o, misalign_o, timeout_o;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_access_unit #(.TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .rw_i(rw), .size_i(size),
    .sign_ext_i(sext), .addr_i(addr), .wdata_i(wdata),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_ack_i(mem_ack),
    .mem_rdata_i(mem_rdata), .dy_o(dy_o), .done_o(done_o), .busy_o(busy_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic mis; logic tmo; logic [31:0] dy; int nreq; } exp_done_t;
  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic we; } exp_bus_t;

  exp_done_t   exp_done_q[$];
  exp_bus_t    exp_bus_q[$];
  int          ntests = 0;
  int          nfail = 0;
  int          cyc = 0;
  int          cur_dly = 0;
  logic [31:0] cur_rdata = '0;
  logic [31:0] model_dy = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic se,
                                             input logic [31:0] a, input logic [31:0] rd);
    int unsigned sh;
    logic [31:0] v;
    sh = (a % 4) * 8;
    v = rd >> sh;
    if (sz == 0) begin
      v = v & 32'h0000_00FF;
      if (se && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = v & 32'h0000_FFFF;
      if (se && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder: ack after cur_dly request cycles; random ack noise while idle.
  initial begin
    int rcnt;
    rcnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req_o) begin
        mem_ack   = (rcnt == cur_dly);
        mem_rdata = mem_ack ? cur_rdata : $urandom;
        rcnt++;
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        rcnt = 0;
      end
    end
  end

  // Monitor: bus attributes on each request cycle, completion results on done.
  initial begin
    exp_bus_t  cb;
    exp_done_t ed;
    logic      prev_req;
    int        nreq;
    cb = '{addr: '0, wdata: '0, be: '0, we: 1'b0};
    prev_req = 1'b0;
    nreq = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        prev_req = 1'b0;
        nreq = 0;
        continue;
      end
      if (mem_req_o) begin
        nreq++;
        if (!prev_req) begin
          if (exp_bus_q.size() == 0) chk("unexpected_req", 32'(mem_req_o), 32'd0);
          else cb = exp_bus_q.pop_front();
        end
        chk("mem_addr", mem_addr_o, cb.addr);
        chk("mem_wdata", mem_wdata_o, cb.wdata);
        chk("mem_be", 32'(mem_be_o), 32'(cb.be));
        chk("mem_we", 32'(mem_we_o), 32'(cb.we));
      end
      prev_req = mem_req_o;
      if (done_o) begin
        if (exp_done_q.size() == 0) begin
          chk("unexpected_done", 32'(done_o), 32'd0);
        end else begin
          ed = exp_done_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(ed.cyc));
          chk("misalign", 32'(misalign_o), 32'(ed.mis));
          chk("timeout", 32'(timeout_o), 32'(ed.tmo));
          chk("dy", dy_o, ed.dy);
          chk("req_cycles", 32'(nreq), 32'(ed.nreq));
          chk("busy_at_done", 32'(busy_o), 32'd1);
        end
        nreq = 0;
      end else begin
        chk("flags_without_done", {30'd0, misalign_o, timeout_o}, 32'd0);
      end
    end
  end

  task automatic issue(input logic r, input logic [1:0] sz, input logic se,
                       input logic [31:0] a, input logic [31:0] wd, input int dly,
                       input logic [31:0] rd, input bit extra);
    int        guard;
    bit        legal;
    exp_done_t ed;
    exp_bus_t  eb;
    guard = 0;
    @(negedge clk);
    while (busy_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("idle_wait_expired", 32'(busy_o), 32'd0);
    legal = (sz == 0) || (sz == 1 && a % 2 == 0) || (sz == 2 && a % 4 == 0);
    ed.mis = !legal;
    ed.tmo = legal && dly >= TMO;
    if (!legal) begin
      ed.cyc = cyc + 1;
      ed.nreq = 0;
    end else if (dly >= TMO) begin
      ed.cyc = cyc + 1 + TMO;
      ed.nreq = TMO;
    end else begin
      ed.cyc = cyc + 2 + dly;
      ed.nreq = dly + 1;
      if (!r) model_dy = model_load(sz, se, a, rd);
    end
    ed.dy = model_dy;
    exp_done_q.push_back(ed);
    if (legal) begin
      eb.addr  = a & ~32'd3;
      eb.we    = r;
      eb.be    = (sz == 0) ? 4'(1 << (a % 4)) : (sz == 1) ? 4'(3 << (a % 4)) : 4'hF;
      eb.wdata = (sz == 0) ? wd[7:0] * 32'h0101_0101 :
                 (sz == 1) ? wd[15:0] * 32'h0001_0001 : wd;
      exp_bus_q.push_back(eb);
    end
    cur_dly = dly;
    cur_rdata = rd;
    start = 1'b1; rw = r; size = sz; sext = se; addr = a; wdata = wd;
    @(negedge clk);
    if (extra) begin
      rw = 1'b0; size = 2'd2; addr = 32'h0000_0020;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    chk("rst_be_we", {27'd0, mem_be_o, mem_we_o}, 32'd0);
    chk("rst_dy", dy_o, 32'd0);
    chk("rst_flags", {28'd0, done_o, busy_o, misalign_o, timeout_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00A5, 2, 32'h0, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h0000_0202, 32'h0, 1, 32'h8001_1234, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0, 0, 32'h8001_1234, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 0, 32'h1111_1111, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 99, 32'h2222_2222, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 32'h0000_0011, 32'h0, TMO - 1, 32'h0000_8000, 1'b0);
    issue(1'b1, 2'd3, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 0, 32'h0, 1'b0);

    // Reset in the middle of a pending load: no completion may follow.
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0080, 32'h0, 5, 32'h3333_3333, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req_o), 32'd0);
    chk("arst_mem_addr", mem_addr_o, 32'd0);
    chk("arst_mem_wdata", mem_wdata_o, 32'd0);
    chk("arst_be_we", {27'd0, mem_be_o, mem_we_o}, 32'd0);
    chk("arst_dy", dy_o, 32'd0);
    chk("arst_flags", {28'd0, done_o, busy_o, misalign_o, timeout_o}, 32'd0);
    exp_done_q.delete();
    exp_bus_q.delete();
    model_dy = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 2'd0, 1'b1, 32'h0000_0005, 32'h0, 1, 32'h0000_9A00, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 1, TMO + 3) : $urandom_range(0, 4);
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, d, $urandom, 1'($urandom_range(0, 3) == 0));
    end

    repeat (TMO + 6) @(negedge clk);
    chk("pending_expectations", 32'(exp_done_q.size() + exp_bus_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, max cycles mem_req waits for mem_ack before abort (range 1..255).
REQ-002 CLK  in  1  sole clock, all state on rising edge.
REQ-003 RESET  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle request strobe from control unit.
REQ-005 rw  in  1  1 = store, 0 = load.
REQ-006 size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved.
REQ-007 sign_ext  in  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-008 addr  in  32  byte address, taken from datapath ALU_OUT.
REQ-009 wdata  in  32  store data, taken from datapath D_OUT.
REQ-010 mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-011 mem_wdata  out  32  lane-replicated store data.
REQ-012 mem_be  out  4  byte enables, bit i = byte lane i (little-endian).
REQ-013 mem_req / mem_we  out  1 each  bus request / write qualifier.
REQ-014 mem_ack  in  1  memory completion; mem_rdata valid same cycle for loads.
REQ-015 mem_rdata  in  32  raw read word.
REQ-016 DY  out  32  aligned, extended load result to datapath DY input.
REQ-017 done / busy / misalign / timeout  out  1 each  completion pulse, in-flight flag, error flags.

Function
REQ-018 FSM states IDLE, REQ, DONE; busy SHALL be 1 in REQ and DONE.
REQ-019 IDLE: start with legal alignment SHALL register addr, wdata, rw, size, sign_ext and enter REQ next edge; mem_req rises the cycle after start.
REQ-020 Alignment legal: byte any; half addr[0]=0; word addr[1:0]=0; size=3 always illegal.
REQ-021 Illegal start SHALL never raise mem_req; next cycle done=1, misalign=1 for one cycle, DY unchanged, return IDLE.
REQ-022 start while busy SHALL be ignored, no queuing.
REQ-023 REQ: mem_req, mem_addr, mem_we, mem_be, mem_wdata SHALL stay stable until mem_ack sampled high.
REQ-024 mem_ack high in REQ: next cycle enter DONE, mem_req=0, done=1 one cycle, loads update DY that edge; then IDLE.
REQ-025 mem_ack outside REQ SHALL be ignored.
REQ-026 Wait counter clears on REQ entry, increments each REQ cycle without ack; reaching TIMEOUT_CYC SHALL drop mem_req, pulse done=1 and timeout=1, leave DY unchanged.
REQ-027 mem_be: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111.
REQ-028 mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-029 Load byte: lane addr[1:0] extracted; half: lane pair addr[1]; extension per sign_ext to 32 bits; word passes unchanged.
REQ-030 Stores SHALL NOT modify DY.
REQ-031 Latency, zero-wait memory (ack first REQ cycle): start at t, mem_req t+1, done and DY valid t+2.
REQ-032 misalign and timeout SHALL be mutually exclusive and only asserted with done.

Reset
REQ-033 RESET low SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, DY=0, done=busy=misalign=timeout=0, counter=0.
REQ-034 Reset during REQ SHALL abandon the transaction with no done pulse; first start after release is handled normally.

Structure
REQ-035 Shared package SHALL hold FSM state encoding, size codes (SZ_BYTE/SZ_HALF/SZ_WORD) and TIMEOUT_CYC default.
REQ-036 One sub-module, load_align (combinational lane select plus extension), SHALL be instantiated once.

Verification
REQ-037 Store byte addr=0x00000103, wdata=0x000000A5 -> mem_addr=0x00000100, mem_be=4'b1000, mem_wdata=0xA5A5A5A5, mem_we=1, done after ack.
REQ-038 Load half signed addr=0x00000202, mem_rdata=0x8001_1234, sign_ext=1 -> DY=0xFFFF8001; sign_ext=0 -> DY=0x00008001.
REQ-039 Word load addr=0x00000006 -> no mem_req, done=1 and misalign=1 at t+1, DY unchanged.
REQ-040 Load with mem_ack held low, TIMEOUT_CYC=16 -> mem_req high exactly 16 cycles, then done=1, timeout=1, DY unchanged.
REQ-041 Zero-wait word load mem_rdata=0xDEADBEEF -> mem_req t+1, done and DY=0xDEADBEEF at t+2; second start at t+1 ignored.
REQ-042 RESET asserted during REQ with ack pending -> mem_req low immediately, all outputs zero, no done pulse.
